// File: rtl/axi_sram_responder_if.sv
// AXI4 slave-side bundle (AW/W/B/AR/R) used to connect axi_sram_responder.
interface axi_sram_responder_if #(
  parameter int ID_W = 7
);
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;

  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;

  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [7:0]      arlen;
  logic [2:0]      arsize;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;

  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready
  );
endinterface

// File: rtl/axi_sram_responder.sv
// AXI4 SRAM slave: independent one-burst read/write FSMs, first read beat 2 cycles after AR, each beat holds until ready.
// Optional AXI_SRAM_BOUNDS_CHECK_EN returns DECERR for addresses above the memory instead of aliasing.
module axi_sram_responder #(
  parameter int MEM_AW = 12,
  parameter int ID_W   = 7
) (
  input  logic                 ui_clk,
  input  logic                 ui_clk_sync_rst,
  axi_sram_responder_if.slave  s_axi
);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

`ifdef AXI_SRAM_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                            input logic [1:0] burst);
    return (burst == 2'b01) ? a + (32'd1 << size) : a;
  endfunction

  function automatic logic burst_bad(input logic [2:0] size, input logic [1:0] burst);
    return burst[1] || (size > 3'd2);
  endfunction

  function automatic logic out_of_range(input logic [31:0] a);
    return BOUNDS_EN && ((a >> (MEM_AW + 2)) != 32'd0);
  endfunction

  logic [31:0] mem [2**MEM_AW];

  // ---------------- write path ----------------
  w_state_e        w_state_q, w_state_d;
  logic            wready_q, wready_d;
  logic            bvalid_q, bvalid_d;
  logic [ID_W-1:0] bid_q, bid_d;
  logic [1:0]      bresp_q, bresp_d;
  logic [ID_W-1:0] aw_id_q, aw_id_d;
  logic [31:0]     w_addr_q, w_addr_d;
  logic [7:0]      w_len_q, w_len_d;
  logic [2:0]      w_size_q, w_size_d;
  logic [1:0]      w_burst_q, w_burst_d;
  logic [8:0]      w_beat_q, w_beat_d;
  logic            w_bad_q, w_bad_d;
  logic            w_dec_q, w_dec_d;
  logic            mem_we;
  logic            w_oob;
  logic            w_in_len;

  assign w_oob    = out_of_range(w_addr_q);
  assign w_in_len = (w_beat_q <= {1'b0, w_len_q});

  always_comb begin
    w_state_d = w_state_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    aw_id_d   = aw_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_beat_d  = w_beat_q;
    w_bad_d   = w_bad_q;
    w_dec_d   = w_dec_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi.awvalid) begin
          w_state_d = W_DATA;
          wready_d  = 1'b1;
          aw_id_d   = s_axi.awid;
          w_addr_d  = s_axi.awaddr;
          w_len_d   = s_axi.awlen;
          w_size_d  = s_axi.awsize;
          w_burst_d = s_axi.awburst;
          w_beat_d  = 9'd0;
          w_bad_d   = burst_bad(s_axi.awsize, s_axi.awburst);
          w_dec_d   = 1'b0;
        end
      end
      W_DATA: begin
        if (s_axi.wvalid && wready_q) begin
          // Beats past len+1 are swallowed so a runaway master cannot scribble memory.
          mem_we   = !w_bad_q && !w_oob && w_in_len && !ui_clk_sync_rst;
          w_dec_d  = w_dec_q || w_oob;
          w_addr_d = next_addr(w_addr_q, w_size_q, w_burst_q);
          if (w_in_len) w_beat_d = w_beat_q + 9'd1;
          if (s_axi.wlast) begin
            w_state_d = W_RESP;
            wready_d  = 1'b0;
            bvalid_d  = 1'b1;
            bid_d     = aw_id_q;
            if (w_bad_q)                           bresp_d = RESP_SLVERR;
            else if (w_dec_q || w_oob)             bresp_d = RESP_DECERR;
            else if (w_beat_q != {1'b0, w_len_q})  bresp_d = RESP_SLVERR;
            else                                   bresp_d = RESP_OKAY;
          end
        end
      end
      W_RESP: begin
        if (s_axi.bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
          bid_d     = '0;
          bresp_d   = RESP_OKAY;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      w_state_q <= W_IDLE;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
      aw_id_q   <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_beat_q  <= '0;
      w_bad_q   <= 1'b0;
      w_dec_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
      aw_id_q   <= aw_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_beat_q  <= w_beat_d;
      w_bad_q   <= w_bad_d;
      w_dec_q   <= w_dec_d;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi.wstrb[b]) mem[w_addr_q[MEM_AW+1:2]][8*b +: 8] <= s_axi.wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e        r_state_q, r_state_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [ID_W-1:0] rid_q, rid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [1:0]      rresp_q, rresp_d;
  logic [ID_W-1:0] ar_id_q, ar_id_d;
  logic [31:0]     r_addr_q, r_addr_d;
  logic [7:0]      r_len_q, r_len_d;
  logic [2:0]      r_size_q, r_size_d;
  logic [1:0]      r_burst_q, r_burst_d;
  logic [7:0]      r_beat_q, r_beat_d;
  logic            r_bad_q, r_bad_d;
  logic [31:0]     r_word;

  // Sampled before the same edge's write lands, giving read-before-write.
  assign r_word = mem[r_addr_q[MEM_AW+1:2]];

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_id_d   = ar_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_beat_d  = r_beat_q;
    r_bad_d   = r_bad_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi.arvalid) begin
          r_state_d = R_FETCH;
          ar_id_d   = s_axi.arid;
          r_addr_d  = s_axi.araddr;
          r_len_d   = s_axi.arlen;
          r_size_d  = s_axi.arsize;
          r_burst_d = s_axi.arburst;
          r_beat_d  = 8'd0;
          r_bad_d   = burst_bad(s_axi.arsize, s_axi.arburst);
        end
      end
      R_FETCH: begin
        r_state_d = R_DATA;
        rvalid_d  = 1'b1;
        rid_d     = ar_id_q;
        rlast_d   = (r_beat_q == r_len_q);
        if (r_bad_q) begin
          rdata_d = 32'd0;
          rresp_d = RESP_SLVERR;
        end else if (out_of_range(r_addr_q)) begin
          rdata_d = 32'd0;
          rresp_d = RESP_DECERR;
        end else begin
          rdata_d = r_word;
          rresp_d = RESP_OKAY;
        end
      end
      R_DATA: begin
        if (s_axi.rready) begin
          r_state_d = rlast_q ? R_IDLE : R_FETCH;
          rvalid_d  = 1'b0;
          rlast_d   = 1'b0;
          r_addr_d  = next_addr(r_addr_q, r_size_q, r_burst_q);
          r_beat_d  = r_beat_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_state_q <= R_IDLE;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      ar_id_q   <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_beat_q  <= '0;
      r_bad_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      ar_id_q   <= ar_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_beat_q  <= r_beat_d;
      r_bad_q   <= r_bad_d;
    end
  end

  // Address readies decode the idle state so they rise right after reset releases.
  assign s_axi.awready = (w_state_q == W_IDLE) && !ui_clk_sync_rst;
  assign s_axi.wready  = wready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bid     = bid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.arready = (r_state_q == R_IDLE) && !ui_clk_sync_rst;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rlast   = rlast_q;
  assign s_axi.rid     = rid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Scoreboard bench for axi_sram_responder: directed bursts, expected B/R responses queued, monitor compares.
module tb_axi_sram_responder;
  localparam int ID_W = 7;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [31:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_exp_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_sram_responder_if #(.ID_W(ID_W)) s_axi ();

  axi_sram_responder #(.MEM_AW(12), .ID_W(ID_W)) dut (
    .ui_clk          (clk),
    .ui_clk_sync_rst (rst),
    .s_axi           (s_axi)
  );

  int n_chk  = 0;
  int n_pass = 0;
  r_exp_t exp_r[$];
  b_exp_t exp_b[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    $display("FAIL %s: timed out or unexpected", name);
  endtask

  // Monitor: scoreboard pops and hold-stability checks, sampled on the falling edge.
  logic   r_stall = 1'b0;
  logic   b_stall = 1'b0;
  r_exp_t r_prev;
  b_exp_t b_prev;
  always @(negedge clk) begin
    if (rst) begin
      r_stall = 1'b0;
      b_stall = 1'b0;
    end else begin
      if (r_stall) begin
        chk("r_hold_vld", 64'(s_axi.rvalid), 64'd1);
        chk("r_hold_dat", 64'({s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast}), 64'(r_prev));
      end
      if (b_stall) begin
        chk("b_hold_vld", 64'(s_axi.bvalid), 64'd1);
        chk("b_hold_dat", 64'({s_axi.bid, s_axi.bresp}), 64'(b_prev));
      end
      if (s_axi.rvalid && s_axi.rready) begin
        if (exp_r.size() == 0) fail_now("r_unexpected");
        else begin
          r_exp_t e;
          e = exp_r.pop_front();
          chk("r_beat", 64'({s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast}), 64'(e));
        end
      end
      if (s_axi.bvalid && s_axi.bready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected");
        else begin
          b_exp_t e;
          e = exp_b.pop_front();
          chk("b_resp", 64'({s_axi.bid, s_axi.bresp}), 64'(e));
        end
      end
      r_stall = s_axi.rvalid && !s_axi.rready;
      r_prev  = {s_axi.rid, s_axi.rdata, s_axi.rresp, s_axi.rlast};
      b_stall = s_axi.bvalid && !s_axi.bready;
      b_prev  = {s_axi.bid, s_axi.bresp};
    end
  end

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    s_axi.awid = id; s_axi.awaddr = addr; s_axi.awlen = len;
    s_axi.awsize = size; s_axi.awburst = burst; s_axi.awvalid = 1'b1;
    @(negedge clk);
    while (!s_axi.awready && n < 100) begin n++; @(negedge clk); end
    if (!s_axi.awready) fail_now("aw_timeout");
    @(posedge clk); #1 s_axi.awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    s_axi.wdata = data; s_axi.wstrb = strb; s_axi.wlast = last; s_axi.wvalid = 1'b1;
    @(negedge clk);
    while (!s_axi.wready && n < 100) begin n++; @(negedge clk); end
    if (!s_axi.wready) fail_now("w_timeout");
    @(posedge clk); #1 s_axi.wvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input bit check_lat);
    int n = 0;
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len;
    s_axi.arsize = size; s_axi.arburst = burst; s_axi.arvalid = 1'b1;
    @(negedge clk);
    while (!s_axi.arready && n < 100) begin n++; @(negedge clk); end
    if (!s_axi.arready) fail_now("ar_timeout");
    @(posedge clk); #1 s_axi.arvalid = 1'b0;
    if (check_lat) begin
      @(negedge clk); chk("r_lat_t1", 64'(s_axi.rvalid), 64'd0);
      @(negedge clk); chk("r_lat_t2", 64'(s_axi.rvalid), 64'd1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 300) begin n++; @(posedge clk); end
    if (exp_r.size() != 0 || exp_b.size() != 0) fail_now("drain");
    @(posedge clk); #1;
  endtask

  task automatic wr1(input logic [ID_W-1:0] id, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input logic [1:0] resp);
    exp_b.push_back('{id: id, resp: resp});
    aw_send(id, addr, 8'd0, 3'd2, 2'b01);
    w_send(data, strb, 1'b1);
    drain();
  endtask

  function automatic void push_r(input logic [ID_W-1:0] id, input logic [31:0] data,
                                 input logic [1:0] resp, input logic last);
    exp_r.push_back('{id: id, data: data, resp: resp, last: last});
  endfunction

  initial begin
    int n;
    s_axi.awvalid = 0; s_axi.wvalid = 0; s_axi.arvalid = 0;
    s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0; s_axi.awsize = '0; s_axi.awburst = '0;
    s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
    s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0; s_axi.arsize = '0; s_axi.arburst = '0;
    s_axi.bready = 1'b1; s_axi.rready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'({s_axi.awready, s_axi.wready, s_axi.arready}), 64'd0);
    chk("rst_valid", 64'({s_axi.bvalid, s_axi.rvalid, s_axi.rlast}), 64'd0);
    chk("rst_data", 64'({s_axi.bid, s_axi.bresp, s_axi.rid, s_axi.rresp, s_axi.rdata}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_ready", 64'({s_axi.awready, s_axi.arready}), 64'b11);
    @(posedge clk); #1;

    // 4-beat INCR write then read-back with latency check
    exp_b.push_back('{id: 7'd5, resp: 2'b00});
    aw_send(7'd5, 32'h100, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hA0 + 32'(i), 4'hF, i == 3);
    drain();
    for (int i = 0; i < 4; i++) push_r(7'd5, 32'hA0 + 32'(i), 2'b00, i == 3);
    ar_send(7'd5, 32'h100, 8'd3, 3'd2, 2'b01, 1'b1);
    drain();

    // FIXED and narrow INCR reads
    push_r(7'd6, 32'hA0, 2'b00, 1'b0); push_r(7'd6, 32'hA0, 2'b00, 1'b1);
    ar_send(7'd6, 32'h100, 8'd1, 3'd2, 2'b00, 1'b0);
    drain();
    push_r(7'd7, 32'hA0, 2'b00, 1'b0); push_r(7'd7, 32'hA0, 2'b00, 1'b0);
    push_r(7'd7, 32'hA1, 2'b00, 1'b0); push_r(7'd7, 32'hA1, 2'b00, 1'b1);
    ar_send(7'd7, 32'h100, 8'd3, 3'd1, 2'b01, 1'b0);
    drain();

    // Byte strobes merge into existing word
    wr1(7'd1, 32'h200, 32'h11223344, 4'hF, 2'b00);
    wr1(7'd1, 32'h200, 32'h00AA0000, 4'b0100, 2'b00);
    push_r(7'd1, 32'h11AA3344, 2'b00, 1'b1);
    ar_send(7'd1, 32'h200, 8'd0, 3'd2, 2'b01, 1'b0);
    drain();

    // Early wlast: SLVERR, single word written
    exp_b.push_back('{id: 7'd2, resp: 2'b10});
    aw_send(7'd2, 32'h300, 8'd1, 3'd2, 2'b01);
    w_send(32'hDEAD0001, 4'hF, 1'b1);
    drain();
    push_r(7'd2, 32'hDEAD0001, 2'b00, 1'b1);
    ar_send(7'd2, 32'h300, 8'd0, 3'd2, 2'b01, 1'b0);
    drain();

    // Extra beat beyond len is dropped and flagged
    wr1(7'd8, 32'h404, 32'h77, 4'hF, 2'b00);
    exp_b.push_back('{id: 7'd9, resp: 2'b10});
    aw_send(7'd9, 32'h400, 8'd0, 3'd2, 2'b01);
    w_send(32'h1, 4'hF, 1'b0);
    w_send(32'h2, 4'hF, 1'b1);
    drain();
    push_r(7'd9, 32'h1, 2'b00, 1'b0); push_r(7'd9, 32'h77, 2'b00, 1'b1);
    ar_send(7'd9, 32'h400, 8'd1, 3'd2, 2'b01, 1'b0);
    drain();

    // WRAP and oversize reads are errors
    push_r(7'd3, 32'h0, 2'b10, 1'b0); push_r(7'd3, 32'h0, 2'b10, 1'b1);
    ar_send(7'd3, 32'h100, 8'd1, 3'd2, 2'b10, 1'b0);
    drain();
    push_r(7'd4, 32'h0, 2'b10, 1'b1);
    ar_send(7'd4, 32'h100, 8'd0, 3'd3, 2'b01, 1'b0);
    drain();

    // rready stall mid-burst
    for (int i = 0; i < 4; i++) push_r(7'd10, 32'hA0 + 32'(i), 2'b00, i == 3);
    ar_send(7'd10, 32'h100, 8'd3, 3'd2, 2'b01, 1'b0);
    n = 0;
    @(negedge clk);
    while (!s_axi.rvalid && n < 20) begin n++; @(negedge clk); end
    @(posedge clk); #1 s_axi.rready = 1'b0;
    repeat (5) @(posedge clk);
    #1 s_axi.rready = 1'b1;
    drain();

    // bready stall
    s_axi.bready = 1'b0;
    exp_b.push_back('{id: 7'd11, resp: 2'b00});
    aw_send(7'd11, 32'h600, 8'd0, 3'd2, 2'b01);
    w_send(32'h5A5A5A5A, 4'hF, 1'b1);
    n = 0;
    @(negedge clk);
    while (!s_axi.bvalid && n < 20) begin n++; @(negedge clk); end
    if (!s_axi.bvalid) fail_now("bvalid_wait");
    repeat (3) @(posedge clk);
    #1 s_axi.bready = 1'b1;
    drain();

    // Reset mid-burst
    exp_b.push_back('{id: 7'd12, resp: 2'b00});
    aw_send(7'd12, 32'h500, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) w_send(32'hB0 + 32'(i), 4'hF, i == 3);
    drain();
    aw_send(7'd13, 32'h500, 8'd3, 3'd2, 2'b01);
    w_send(32'hC0, 4'hF, 1'b0);
    w_send(32'hC1, 4'hF, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ready", 64'({s_axi.awready, s_axi.wready, s_axi.arready}), 64'd0);
    chk("mid_rst_valid", 64'({s_axi.bvalid, s_axi.rvalid, s_axi.rlast}), 64'd0);
    chk("mid_rst_data", 64'({s_axi.bid, s_axi.bresp, s_axi.rid, s_axi.rresp, s_axi.rdata}), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_awready", 64'(s_axi.awready), 64'd1);
    @(posedge clk); #1;
    push_r(7'd14, 32'hC0, 2'b00, 1'b0); push_r(7'd14, 32'hC1, 2'b00, 1'b0);
    push_r(7'd14, 32'hB2, 2'b00, 1'b0); push_r(7'd14, 32'hB3, 2'b00, 1'b1);
    ar_send(7'd14, 32'h500, 8'd3, 3'd2, 2'b01, 1'b0);
    drain();

    // Address above the memory: DECERR or alias of word 0
    wr1(7'd15, 32'h0, 32'h600DF00D, 4'hF, 2'b00);
`ifdef AXI_SRAM_BOUNDS_CHECK_EN
    push_r(7'd16, 32'h0, 2'b11, 1'b1);
`else
    push_r(7'd16, 32'h600DF00D, 2'b00, 1'b1);
`endif
    ar_send(7'd16, 32'h4000, 8'd0, 3'd2, 2'b01, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/axi_sram_responder.md
AXI_SRAM_RESPONDER -- requirements
Module: axi_sram_responder

Interface
REQ-001 Parameter MEM_AW, default 12, SHALL set memory depth to 2^MEM_AW 32-bit words.
REQ-002 Parameter ID_W, default 7, SHALL set AXI ID width.
REQ-003 ui_clk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-004 ui_clk_sync_rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 s_axi_aw{id,addr,len,size,burst,valid}  in  ID_W/32/8/3/2/1 and s_axi_awready  out  1 SHALL form the AW channel.
REQ-006 s_axi_w{data,strb,last,valid}  in  32/4/1/1 and s_axi_wready  out  1 SHALL form the W channel.
REQ-007 s_axi_b{id,resp,valid}  out  ID_W/2/1 and s_axi_bready  in  1 SHALL form the B channel.
REQ-008 s_axi_ar{id,addr,len,size,burst,valid}  in  ID_W/32/8/3/2/1 and s_axi_arready  out  1 SHALL form the AR channel.
REQ-009 s_axi_r{id,data,resp,last,valid}  out  ID_W/32/2/1/1 and s_axi_rready  in  1 SHALL form the R channel.

Function
REQ-010 Read and write paths SHALL be independent FSMs, each with at most one outstanding burst.
REQ-011 Word index SHALL be addr[MEM_AW+1:2]; higher bits alias unless REQ-030 applies.
REQ-012 Burst FIXED(00) SHALL keep the address; INCR(01) SHALL add (1<<size) per beat, carries past word boundary advancing the index.
REQ-013 WRAP(10), reserved burst (11), or size>2 SHALL be an error burst: no memory write, rdata=0, resp SLVERR(10) on all beats/B.
REQ-014 Write FSM states W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1); AW handshake -> W_DATA; W handshake with wlast -> W_RESP; B handshake -> W_IDLE.
REQ-015 Each W handshake in W_DATA SHALL write bytes enabled by wstrb to the current word in the same cycle; wstrb=0 writes nothing.
REQ-016 Beats after len+1 without wlast SHALL be accepted but not written; wlast before beat len+1 or beat count != len+1 SHALL give bresp SLVERR, else OKAY(00).
REQ-017 bid SHALL equal the latched awid; bvalid SHALL hold with bid/bresp stable until bready.
REQ-018 Read FSM states R_IDLE (arready=1), R_FETCH, R_DATA (rvalid=1); AR handshake -> R_FETCH; R_FETCH -> R_DATA; R handshake -> R_IDLE if rlast else R_FETCH.
REQ-019 AR handshake at cycle T SHALL give first rvalid at T+2; subsequent beats SHALL be 2 cycles after the previous R handshake.
REQ-020 rid/rdata/rresp/rlast SHALL be stable while rvalid && !rready; rlast SHALL assert only on beat len+1.
REQ-021 Read and write to the same word in the same cycle SHALL return old data (read-before-write).
REQ-022 awready SHALL be low outside W_IDLE; arready low outside R_IDLE; no channel SHALL block another.

Reset
REQ-023 Reset asserted at any edge SHALL force W_IDLE and R_IDLE, abandoning bursts in flight without further memory writes.
REQ-024 During reset awready, wready, bvalid, arready, rvalid, rlast SHALL be 0; bid, bresp, rid, rresp, rdata SHALL be 0.
REQ-025 awready and arready SHALL rise the first cycle after reset deasserts.
REQ-026 Memory contents SHALL NOT be reset.

Configuration
REQ-030 With macro AXI_SRAM_BOUNDS_CHECK_EN defined, any burst whose start address has nonzero bits above MEM_AW+1 SHALL respond DECERR(11) on all beats/B, no writes, rdata=0; INCR crossing the top SHALL DECERR from the crossing beat.
REQ-031 Without AXI_SRAM_BOUNDS_CHECK_EN, upper address bits SHALL be ignored (aliasing) and DECERR never returned.

Verification
REQ-040 AW id=5 addr=0x100 len=3 size=2 INCR, data 0xA0..0xA3 strb=F -> bid=5 OKAY; AR same -> rid=5, rdata 0xA0..0xA3, rlast on 4th beat, first rvalid 2 cycles after AR.
REQ-041 Write 0x11223344 to 0x200 then strb=0100 data 0x00AA0000 -> read 0x200 returns 0x11AA3344.
REQ-042 AW len=1 with wlast on first beat -> bresp SLVERR, one word written; AR burst=WRAP -> all rresp SLVERR, rdata=0.
REQ-043 rready low 5 cycles mid-burst -> rdata/rlast stable, no beat lost; bready low 3 cycles -> bvalid held.
REQ-044 Assert reset during W_DATA after 2 of 4 beats -> all outputs 0, awready=1 next cycle, remaining words unchanged.
REQ-045 With AXI_SRAM_BOUNDS_CHECK_EN, MEM_AW=12, AR addr=0x4000 -> rresp DECERR, rdata=0; without macro -> data of addr 0x0.
